// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver that presents 7-bit ASCII characters with a one-cycle ready strobe,
// flags framing errors, and qualifies the digits '0'..'3' for the downstream encoder.
module uart_rx_ascii #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [6:0] ascii_out,
  output logic       data_ready,
  output logic       is_digit,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StStop, StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [6:0]      ascii_q, ascii_d;
  logic            digit_q, digit_d;
  logic            ready_q, ready_d;
  logic            fe_q, fe_d;
  logic            rx_meta_q, rx_s_q;

  // Synchroniser resets to the idle-high line level so reset release never looks like a start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ascii_q <= '0;
      digit_q <= 1'b0;
      ready_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ascii_q <= ascii_d;
      digit_q <= digit_d;
      ready_q <= ready_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ascii_d = ascii_q;
    digit_d = digit_q;
    ready_d = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            ascii_d = shift_q[6:0];
            digit_d = (shift_q >= 8'h30) && (shift_q <= 8'h33);
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d    = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Hold off until the line idles so a break cannot start a bogus frame.
      StWaitHigh: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ascii_out     = ascii_q;
  assign is_digit      = digit_q;
  assign data_ready    = ready_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Scoreboard bench for uart_rx_ascii: frames are queued as they are sent and checked as
// data_ready strobes arrive.
module tb_uart_rx_ascii;

  localparam int unsigned Cpb = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [6:0] ascii_out;
  logic       data_ready, is_digit, framing_error, busy;

  uart_rx_ascii #(.CLKS_PER_BIT(Cpb)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .ascii_out     (ascii_out),
    .data_ready    (data_ready),
    .is_digit      (is_digit),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_cnt  = 0;
  int fe_cnt   = 0;
  logic [7:0] exp_q[$];
  logic       prev_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Scoreboard side: every ready strobe must match the oldest queued frame.
  always @(negedge clock) begin
    if (reset_n) begin
      if (prev_ready) chk("ready_width", {31'd0, data_ready}, 32'd0);
      if (data_ready || framing_error)
        chk("ready_fe_excl", {31'd0, data_ready & framing_error}, 32'd0);
      if (framing_error) fe_cnt++;
      if (data_ready) begin
        rdy_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", {25'd0, ascii_out}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] b;
          b = exp_q.pop_front();
          chk("ascii_out", {25'd0, ascii_out}, {25'd0, b[6:0]});
          chk("is_digit", {31'd0, is_digit}, {31'd0, (b >= 8'h30 && b <= 8'h33)});
        end
      end
      prev_ready = data_ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (Cpb) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clock);
    end
    rx = stop;
    repeat (Cpb) @(negedge clock);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  initial begin
    logic seen_busy;
    logic [7:0] rb;
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_ascii", {25'd0, ascii_out}, 32'd0);
    chk("rst_digit", {31'd0, is_digit}, 32'd0);
    chk("rst_ready", {31'd0, data_ready}, 32'd0);
    chk("rst_fe", {31'd0, framing_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // Digit and non-digit characters.
    send_good(8'h32);
    repeat (10) @(negedge clock);
    send_good(8'h41);
    repeat (10) @(negedge clock);
    send_good(8'hB1);
    repeat (10) @(negedge clock);

    // Glitch: two-cycle low pulse must be rejected.
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (busy) seen_busy = 1'b1;
    end
    chk("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    chk("glitch_ascii", {25'd0, ascii_out}, 32'h31);

    // Framing error followed by a stuck-low line.
    send_frame(8'h33, 1'b0);
    repeat (30) @(negedge clock);
    chk("wait_high_busy", {31'd0, busy}, 32'd1);
    chk("fe_ascii_kept", {25'd0, ascii_out}, 32'h31);
    chk("fe_digit_kept", {31'd0, is_digit}, 32'd0);
    rx = 1'b1;
    repeat (4) @(negedge clock);
    chk("wait_high_release", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clock);

    // Back-to-back frames with no idle time.
    send_good(8'h30);
    send_good(8'h31);
    send_good(8'h33);
    repeat (10) @(negedge clock);

    // Reset during data bit 4 of 8'h32.
    rb = 8'h32;
    rx = 1'b0;
    repeat (Cpb) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      repeat (Cpb) @(negedge clock);
    end
    rx = rb[4];
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ascii", {25'd0, ascii_out}, 32'd0);
    chk("mid_rst_digit", {31'd0, is_digit}, 32'd0);
    chk("mid_rst_ready", {31'd0, data_ready}, 32'd0);
    chk("mid_rst_fe", {31'd0, framing_error}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    send_good(8'h31);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("ready_count", rdy_cnt, 32'd7);
    chk("fe_count", fe_cnt, 32'd1);
    chk("final_ascii", {25'd0, ascii_out}, 32'h31);
    chk("final_digit", {31'd0, is_digit}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ascii.md
# uart_rx_ascii

Serial receive front end for the digit-input path: deserialises an 8N1 UART stream into 7-bit ASCII characters. Each correctly framed character is presented on `ascii_out` with a one-cycle `data_ready` strobe. The block sits directly upstream of the ASCII-to-2-bit digit encoder. `is_digit` qualifies characters '0'–'3' so downstream logic can discard anything else.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx` in 1: asynchronous serial line, idle high.
- `ascii_out` out 7: bits [6:0] of the last correctly framed byte.
- `data_ready` out 1: one-cycle strobe when `ascii_out`/`is_digit` update.
- `is_digit` out 1: high when the last accepted byte is 8'h30–8'h33.
- `framing_error` out 1: one-cycle strobe when a stop bit is sampled low.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser; all logic uses the synchronised value `rx_s`. The synchroniser flops reset to 1.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- **IDLE**: the bit counter and cycle counter are cleared. Go to START on `rx_s` == 0.
- **START**: count `(CLKS_PER_BIT-1)/2` cycles (integer division), then sample `rx_s`.
  - Sample 0: clear the cycle counter and go to DATA.
  - Sample 1: false start, glitch rejected; return to IDLE with no output change.
- **DATA**: every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register, LSB first. After the 8th sample, go to STOP.
- **STOP**: after `CLKS_PER_BIT` cycles, sample `rx_s`.
  - Sample 1: load `ascii_out` <= shift[6:0]. Load `is_digit` <= (shift[7:0] >= 8'h30 && shift[7:0] <= 8'h33); bit 7 set therefore gives `is_digit` = 0. Pulse `data_ready` and return to IDLE.
  - Sample 0: pulse `framing_error`, leave `ascii_out`/`is_digit` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH**: remain until `rx_s` == 1, then go to IDLE. This prevents a break or stuck-low line from re-triggering frames.
- `ascii_out` and `is_digit` hold their values between accepted characters.
- `data_ready` and `framing_error` are never high in the same cycle.
- Encoding: a one-hot or binary state encoding may be used. Illegal states recover to IDLE.

## Timing
- Reset (asynchronous, any state, including mid-frame) forces:
  - state IDLE, all counters 0, shift register 0;
  - `ascii_out` = 7'h00, `is_digit` = 0, `data_ready` = 0, `framing_error` = 0, `busy` = 0.
- The first frame after reset is received normally, provided `rx` has been high for at least 2 clocks.
- `busy` rises 1 cycle after `rx_s` falls, i.e. 3 clocks after the `rx` falling edge.
- Sample points, measured from the START entry cycle:
  - start bit: `(CLKS_PER_BIT-1)/2`;
  - data bit k: that value + (k+1)·`CLKS_PER_BIT`;
  - stop bit: that value + 9·`CLKS_PER_BIT`.
- `data_ready` / `framing_error` are registered and assert the cycle after the stop sample. The state is IDLE in that same cycle, so `busy` = 0.
- Back-to-back frames are supported: the next start edge may arrive immediately after the mid-stop sample, with no idle time required.
- Tolerated baud mismatch is ±4% accumulated over a frame; the block does not detect it.

## Test plan
- **Digit character**: `CLKS_PER_BIT`=8, send 8'h32.
  - `data_ready` pulses exactly once for 1 cycle.
  - `ascii_out` = 7'h32, `is_digit` = 1, `framing_error` never asserted.
- **Non-digit characters**: send 8'h41 ('A'), then 8'hB1.
  - 8'h41: `ascii_out` = 7'h41, `is_digit` = 0.
  - 8'hB1: `ascii_out` = 7'h31, `is_digit` = 0.
- **Glitch rejection**: drive `rx` low for 2 cycles, then high (`CLKS_PER_BIT`=8).
  - `busy` pulses briefly, then returns to 0.
  - No `data_ready`; `ascii_out` is unchanged.
- **Framing error**: send 8'h33 with the stop bit at 0, then hold `rx` low 30 cycles, then release high.
  - One `framing_error` pulse, no `data_ready`, previous `ascii_out`/`is_digit` retained.
  - `busy` stays high until 2 cycles after `rx` returns high.
- **Back-to-back frames**: send 8'h30, 8'h31, 8'h33 with zero idle between frames.
  - Three `data_ready` pulses, with `ascii_out` = 7'h30, 7'h31, 7'h33 and `is_digit` = 1 each time.
- **Reset mid-frame**: assert `reset_n` low during data bit 4 of 8'h32.
  - All outputs are at reset values immediately, before the next clock edge.
  - After release, a fresh 8'h31 frame yields `ascii_out` = 7'h31.
